diff_seq_ctrl: RTL and testbench
================================

Name: diff_seq_ctrl

Overview:
- Multi-cycle sequencer for the KGP-miniRISC "diff" instruction.
- Computes the index of the least-significant bit position where two register operands differ.
- Sits beside the ALU; the execute-stage control issues start and stalls on busy until done, then writes diff_bit to rd.
- Replaces a flat 32-way compare chain with a shift-scan FSM (or an optional single-cycle fast path).

Parameters:
- WIDTH, 32, operand width in bits.
- IDX_W, 5, width of the scan counter; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- op_a  input  WIDTH  first operand; captured at start.
- op_b  input  WIDTH  second operand; captured at start.
- busy  output  1  high in SCAN and DONE.
- done  output  1  single-cycle completion pulse.
- diff_bit  output  WIDTH  zero-extended index of the lowest differing bit; held until the next accepted start.
- no_diff  output  1  operands were equal; held with diff_bit.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- Reset: state=IDLE; busy=0, done=0, diff_bit=0, no_diff=0; scan register and counter cleared.
- States: IDLE, SCAN, DONE.
- IDLE, start=1 at edge T:
  - x <= op_a ^ op_b; cnt <= 0.
  - diff_bit <= 0; no_diff <= 0.
  - go to SCAN.
- IDLE, start=0: remain in IDLE.
- SCAN, checked in this priority order each edge:
  - x==0: no_diff <= 1, diff_bit <= 0, go to DONE.
  - else x[0]==1: diff_bit <= cnt (zero-extended), go to DONE.
  - else: x <= x>>1, cnt <= cnt+1, stay in SCAN.
- DONE: done=1 for exactly one cycle, busy=1, unconditional return to IDLE.
- Latency:
  - Lowest differing bit k: done is high in the cycle after edge T+1+k. Best case is 2 cycles after start (k=0); worst case is 33 (k=31).
  - Equal operands: done after edge T+1.
- Boundaries:
  - cnt never wraps, because x becomes 0 before cnt passes WIDTH-1.
  - start while busy (SCAN or DONE) is ignored, with no queuing.
  - start on the same cycle done is high is ignored; it is accepted on the following IDLE cycle.
  - op_a and op_b changing after capture have no effect.
  - rst mid-SCAN: next cycle is IDLE with all outputs at reset values, no done pulse, and the partial result discarded.
  - rst has priority over start.

Optional Feature:
- Macro: DIFF_SEQ_FAST_EN.
- Defined:
  - SCAN resolves in one edge, using diff_lsb_isolate (x & -x) plus a one-hot-to-index encoder.
  - Latency is fixed: done after edge T+1 for every operand pair.
  - no_diff and diff_bit values are identical to the scan mode.
- Undefined: shift-scan as specified above; the encoder and isolate logic are not instantiated.

Decomposition:
- Shared package diff_pkg:
  - state encoding typedef (IDLE=2'd0, SCAN=2'd1, DONE=2'd2).
  - WIDTH_DEF=32 and IDX_W_DEF=5 constants.
  - DIFF_NONE result constant (0).
- Sub-module diff_lsb_isolate (combinational): input x, outputs lowest-set-bit one-hot and its index. Used only under DIFF_SEQ_FAST_EN.
- FSM, counter and result registers stay in diff_seq_ctrl.

Test Plan:
- op_a=0x0000000F, op_b=0x0000000E, start at T -> done high after edge T+1, diff_bit=0, no_diff=0, busy high for 2 cycles.
- op_a=0x00000000, op_b=0x80000000 -> diff_bit=31, done after edge T+32; done is a single pulse; busy drops the cycle after done.
- op_a=op_b=0xDEADBEEF -> no_diff=1, diff_bit=0, done after edge T+1; outputs held until the next start.
- op_a=0, op_b=0x00001000, second start asserted at T+3 with different operands -> second start ignored, diff_bit=12; a start during the done cycle is also ignored.
- op_a=0, op_b=0x00010000, rst asserted at T+5 -> IDLE next cycle, busy=0, done never pulses, diff_bit=0; a fresh start then yields 16 correctly.
- DIFF_SEQ_FAST_EN defined, op_a=0x0, op_b=0x40000000 -> diff_bit=30, done after edge T+1; repeat with equal operands -> no_diff=1 at the same latency.

Source files
------------

// File: rtl/diff_pkg.sv
// Shared encodings and defaults for the diff instruction sequencer.
package diff_pkg;

    typedef logic [1:0] diff_state_t;

    localparam diff_state_t ST_IDLE = 2'd0;
    localparam diff_state_t ST_SCAN = 2'd1;
    localparam diff_state_t ST_DONE = 2'd2;

    localparam int WIDTH_DEF = 32;
    localparam int IDX_W_DEF = 5;
    localparam int DIFF_NONE = 0;

endpackage

// File: rtl/diff_lsb_isolate.sv
// Isolates the lowest set bit of x (x & -x) and encodes its position.
// Only instantiated when DIFF_SEQ_FAST_EN is defined.
module diff_lsb_isolate #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] idx
);

    assign onehot = x & (~x + WIDTH'(1));

    // onehot has at most one bit set, so OR-ing positions is an exact encode
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/diff_seq_ctrl.sv
// Sequencer for the "diff" instruction: index of the lowest bit where op_a and op_b differ.
// Define DIFF_SEQ_FAST_EN for a single-edge resolve instead of the shift-scan.
//
// state | meaning
// IDLE  | waiting for start; result outputs hold the last answer
// SCAN  | searching x = op_a ^ op_b for its lowest set bit
// DONE  | one-cycle done pulse, busy still high
module diff_seq_ctrl
    import diff_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff_bit,
    output logic             no_diff
);

    diff_state_t      state_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] diff_bit_q;
    logic             no_diff_q;

`ifdef DIFF_SEQ_FAST_EN
    logic [WIDTH-1:0] lsb_onehot;
    logic [IDX_W-1:0] lsb_idx;

    diff_lsb_isolate #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_isolate (
        .x      (x_q),
        .onehot (lsb_onehot),
        .idx    (lsb_idx)
    );
`else
    logic [IDX_W-1:0] cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            diff_bit_q <= WIDTH'(DIFF_NONE);
            no_diff_q  <= 1'b0;
`ifndef DIFF_SEQ_FAST_EN
            cnt_q      <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        x_q        <= op_a ^ op_b;
                        diff_bit_q <= WIDTH'(DIFF_NONE);
                        no_diff_q  <= 1'b0;
`ifndef DIFF_SEQ_FAST_EN
                        cnt_q      <= '0;
`endif
                        state_q    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
`ifdef DIFF_SEQ_FAST_EN
                    if (lsb_onehot == '0) begin
                        no_diff_q  <= 1'b1;
                        diff_bit_q <= WIDTH'(DIFF_NONE);
                    end else begin
                        diff_bit_q <= WIDTH'(lsb_idx);
                    end
                    state_q <= ST_DONE;
`else
                    // x reaches zero before cnt could pass WIDTH-1, so cnt never wraps
                    if (x_q == '0) begin
                        no_diff_q  <= 1'b1;
                        diff_bit_q <= WIDTH'(DIFF_NONE);
                        state_q    <= ST_DONE;
                    end else if (x_q[0]) begin
                        diff_bit_q <= WIDTH'(cnt_q);
                        state_q    <= ST_DONE;
                    end else begin
                        x_q   <= x_q >> 1;
                        cnt_q <= cnt_q + IDX_W'(1);
                    end
`endif
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state_q == ST_SCAN) || (state_q == ST_DONE);
    assign done     = (state_q == ST_DONE);
    assign diff_bit = diff_bit_q;
    assign no_diff  = no_diff_q;

endmodule

// File: tb/tb_diff_seq_ctrl.sv
// Randomized and directed checks of diff_seq_ctrl against a bit-search reference model.
module tb_diff_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] diff_bit;
    logic        no_diff;

    int total = 0;
    int bad   = 0;

    diff_seq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .diff_bit (diff_bit),
        .no_diff  (no_diff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // -1 when the operands are equal
    function automatic int ref_lowest_diff(input logic [31:0] a, input logic [31:0] b);
        for (int k = 0; k < 32; k++) begin
            if (a[k] != b[k]) return k;
        end
        return -1;
    endfunction

    function automatic int ref_latency(input int k);
`ifdef DIFF_SEQ_FAST_EN
        return 1;
`else
        return (k < 0) ? 1 : k + 1;
`endif
    endfunction

    // Issues one start, optionally jams start/operands while busy, checks result and timing.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit noisy);
        int k;
        int n;
        bit got;
        k = ref_lowest_diff(a, b);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        n   = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                op_a  = $urandom;
                op_b  = $urandom;
            end
            @(posedge clk);
            #1;
            n++;
            if (done) got = 1'b1;
            else chk("busy_while_scan", {31'd0, busy}, 32'd1);
        end
        chk("done_latency", n, ref_latency(k));
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        chk("diff_bit", diff_bit, (k < 0) ? 32'd0 : k);
        chk("no_diff", {31'd0, no_diff}, (k < 0) ? 32'd1 : 32'd0);
        // start during the done cycle must be ignored
        start = noisy ? 1'b1 : 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_single_pulse", {31'd0, done}, 32'd0);
        chk("busy_drops", {31'd0, busy}, 32'd0);
        chk("diff_bit_held", diff_bit, (k < 0) ? 32'd0 : k);
    endtask

    initial begin
        int  kk;
        int  seen;
        logic [31:0] a;
        logic [31:0] b;

        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_diff_bit", diff_bit, 32'd0);
        chk("rst_no_diff", {31'd0, no_diff}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'h0000_000F, 32'h0000_000E, 1'b0);
        run_op(32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("no_diff_held_idle", {31'd0, no_diff}, 32'd1);
        run_op(32'h0000_0000, 32'h0000_1000, 1'b1);
        run_op(32'h0000_0000, 32'h4000_0000, 1'b0);

        // reset mid-scan: partial result discarded, no done pulse
        @(negedge clk);
        op_a  = 32'h0;
        op_b  = 32'h0001_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen  = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_diff_bit", diff_bit, 32'd0);
        chk("midrst_no_diff", {31'd0, no_diff}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("midrst_no_done", seen, 32'd0);
        run_op(32'h0000_0000, 32'h0001_0000, 1'b0);

        for (int i = 0; i < 30; i++) begin
            a  = $urandom;
            kk = $urandom_range(0, 32);
            b  = (kk == 32) ? a : a ^ (({$urandom} | 32'd1) << kk);
            run_op(a, b, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
